// File: rtl/sum_seg_scanner.sv
// Display end of the 4-bit adder: latches A, B and {CO,SUM} on LOAD and scans them onto a
// 4-digit common-anode 7-segment display (A hex, B hex, result as decimal 00..31).
module sum_seg_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2,
  parameter int LZ_BLANK    = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [3:0] sum_i,
  input  logic       co_i,
  input  logic       load_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       loaded_o
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;
  localparam logic [6:0]    SEG_OFF   = 7'h7F;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [3:0]    a_q, b_q;
  logic [4:0]    v_q;
  logic          loaded_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [1:0]    tens;
  logic [3:0]    units;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Result is at most 31, so three threshold compares replace a divider.
  always_comb begin
    tens  = 2'd0;
    units = v_q[3:0];
    if (v_q >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(v_q - 5'd30);
    end else if (v_q >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(v_q - 5'd20);
    end else if (v_q >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(v_q - 5'd10);
    end
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    sel_d = sel_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  // Digit content is decoded from the current SEL, so SEG/DP settle during the blank window.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = SEG_DASH;
    dp_d  = 1'b1;
    if (cnt_q >= BLANK_END) an_d[sel_q] = 1'b0;
    if (loaded_q) begin
      case (sel_q)
        2'd3: seg_d = hex7(a_q);
        2'd2: begin
          seg_d = hex7(b_q);
          dp_d  = 1'b0;
        end
        2'd1: seg_d = ((LZ_BLANK != 0) && (tens == 2'd0)) ? SEG_OFF : hex7({2'b00, tens});
        default: seg_d = hex7(units);
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      sel_q    <= 2'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      v_q      <= 5'd0;
      loaded_q <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
      if (load_i) begin
        a_q      <= a_i;
        b_q      <= b_i;
        v_q      <= {co_i, sum_i};
        loaded_q <= 1'b1;
      end
    end
  end

  assign an_o     = an_q;
  assign seg_o    = seg_q;
  assign dp_o     = dp_q;
  assign loaded_o = loaded_q;

endmodule

// File: tb/tb_sum_seg_scanner.sv
// Directed bench for sum_seg_scanner with REFRESH_DIV=8, BLANK_CYC=2, LZ_BLANK=1.
// Expected segment codes are hand-computed per vector.
module tb_sum_seg_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b, sum;
  logic       co, load;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, loaded;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       co;
    logic [6:0] s3;
    logic [6:0] s2;
    logic [6:0] s1;
    logic [6:0] s0;
  } vec_t;

  vec_t vecs[11];

  sum_seg_scanner #(.REFRESH_DIV(8), .BLANK_CYC(2), .LZ_BLANK(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b), .sum_i(sum), .co_i(co),
    .load_i(load), .an_o(an), .seg_o(seg), .dp_o(dp), .loaded_o(loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic int digit_of(input logic [3:0] v);
    case (v)
      4'b1110: digit_of = 0;
      4'b1101: digit_of = 1;
      4'b1011: digit_of = 2;
      4'b0111: digit_of = 3;
      4'b1111: digit_of = -1;
      default: digit_of = 9;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input vec_t v, input int d);
    case (d)
      3: exp_seg = v.s3;
      2: exp_seg = v.s2;
      1: exp_seg = v.s1;
      default: exp_seg = v.s0;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] r;
    r = 4'b1111;
    r[d] = 1'b0;
    return r;
  endfunction

  task automatic apply_load(input vec_t v);
    a = v.a; b = v.b; sum = v.sum; co = v.co; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // One full scan period: every lit cycle checked against the vector, plus slot timing.
  task automatic observe_period(input vec_t v);
    int lit[4];
    int blank;
    int d;
    lit = '{0, 0, 0, 0};
    blank = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      d = digit_of(an);
      if (d < 0) blank++;
      else if (d > 3) chk("an_onehot", {28'd0, an}, 32'hF);
      else begin
        lit[d]++;
        chk($sformatf("seg_d%0d", d), {25'd0, seg}, {25'd0, exp_seg(v, d)});
        chk($sformatf("dp_d%0d", d), {31'd0, dp}, (d == 2) ? 32'd0 : 32'd1);
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("lit_cycles_d%0d", k), lit[k], 32'd6);
    chk("blank_cycles", blank, 32'd8);
    chk("loaded", {31'd0, loaded}, 32'd1);
  endtask

  initial begin
    int d, prev, sync_d;
    bit found;
    vecs[0]  = '{4'h9, 4'h7, 4'h0, 1'b1, 7'b0010000, 7'b1111000, 7'b1111001, 7'b0000010}; // 16
    vecs[1]  = '{4'hF, 4'hF, 4'hE, 1'b1, 7'b0001110, 7'b0001110, 7'b0110000, 7'b1000000}; // 30
    vecs[2]  = '{4'h2, 4'h3, 4'h5, 1'b0, 7'b0100100, 7'b0110000, 7'b1111111, 7'b0010010}; // 5
    vecs[3]  = '{4'h0, 4'hA, 4'h3, 1'b1, 7'b1000000, 7'b0001000, 7'b1111001, 7'b0010000}; // 19
    vecs[4]  = '{4'hC, 4'hD, 4'hF, 1'b1, 7'b1000110, 7'b0100001, 7'b0110000, 7'b1111001}; // 31
    vecs[5]  = '{4'h4, 4'hB, 4'hF, 1'b0, 7'b0011001, 7'b0000011, 7'b1111001, 7'b0010010}; // 15
    vecs[6]  = '{4'hE, 4'h8, 4'h4, 1'b1, 7'b0000110, 7'b0000000, 7'b0100100, 7'b1000000}; // 20
    vecs[7]  = '{4'h1, 4'h6, 4'hA, 1'b0, 7'b1111001, 7'b0000010, 7'b1111001, 7'b1000000}; // 10
    vecs[8]  = '{4'h5, 4'h4, 4'h9, 1'b0, 7'b0010010, 7'b0011001, 7'b1111111, 7'b0010000}; // 9
    vecs[9]  = '{4'h7, 4'h2, 4'hD, 1'b1, 7'b1111000, 7'b0100100, 7'b0100100, 7'b0010000}; // 29
    vecs[10] = '{4'h0, 4'h0, 4'h0, 1'b0, 7'b1000000, 7'b1000000, 7'b1111111, 7'b1000000}; // 0

    a = 4'd0; b = 4'd0; sum = 4'd0; co = 1'b0; load = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_dp", {31'd0, dp}, 32'd1);
    chk("rst_loaded", {31'd0, loaded}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released, idle scan");

    // Idle scan: two blank cycles, then SEL0, digits advance in order, dashes everywhere.
    prev = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      d = digit_of(an);
      if (c < 2) chk("idle_first_blank", {28'd0, an}, 32'hF);
      if (c == 2) chk("idle_first_sel0", {28'd0, an}, 32'hE);
      if (d > 3) chk("idle_an_onehot", {28'd0, an}, 32'hF);
      else if (d >= 0) begin
        chk("idle_seg", {25'd0, seg}, 32'b0111111);
        chk("idle_dp", {31'd0, dp}, 32'd1);
        if (prev >= 0 && d != prev) chk("idle_order", d, (prev + 1) % 4);
        prev = d;
      end
      if (c % 16 == 0) chk("idle_loaded", {31'd0, loaded}, 32'd0);
    end

    foreach (vecs[i]) begin
      apply_load(vecs[i]);
      @(negedge clk);
      @(negedge clk);
      $display("[TB] vector %0d: A=%h B=%h V=%0d", i, vecs[i].a, vecs[i].b, {vecs[i].co, vecs[i].sum});
      observe_period(vecs[i]);
    end

    // LOAD on the wrap edge: the slot being left keeps old data, the next slot shows new data.
    found = 0;
    prev = -1;
    sync_d = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      d = digit_of(an);
      if (d < 0 && prev >= 0 && prev <= 3) begin
        found = 1;
        sync_d = prev;
      end
      prev = d;
    end
    chk("wrap_sync_found", {31'd0, found}, 32'd1);
    if (found) begin
      $display("[TB] wrap load after slot %0d", sync_d);
      chk("wrap_blank_holds_next", {25'd0, seg}, {25'd0, exp_seg(vecs[10], (sync_d + 1) % 4)});
      repeat (6) @(negedge clk);
      a = vecs[1].a; b = vecs[1].b; sum = vecs[1].sum; co = vecs[1].co; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("wrap_old_slot_an", {28'd0, an}, {28'd0, an_of((sync_d + 1) % 4)});
      chk("wrap_old_slot_seg", {25'd0, seg}, {25'd0, exp_seg(vecs[10], (sync_d + 1) % 4)});
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk($sformatf("wrap_an_c%0d", c), {28'd0, an},
            (c < 2) ? 32'hF : {28'd0, an_of((sync_d + 2) % 4)});
        chk($sformatf("wrap_seg_c%0d", c), {25'd0, seg},
            {25'd0, exp_seg(vecs[1], (sync_d + 2) % 4)});
      end
      @(negedge clk);
      chk("wrap_next_blank", {28'd0, an}, 32'hF);
    end

    // Asynchronous reset mid-slot, then the scan restarts from SEL0.
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] async reset mid-slot");
    chk("async_an", {28'd0, an}, 32'hF);
    chk("async_seg", {25'd0, seg}, 32'h7F);
    chk("async_dp", {31'd0, dp}, 32'd1);
    chk("async_loaded", {31'd0, loaded}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("restart_an_c%0d", c), {28'd0, an}, (c < 2) ? 32'hF : 32'hE);
      chk($sformatf("restart_seg_c%0d", c), {25'd0, seg}, 32'b0111111);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
